// File: rtl/pc_unit.sv
// Program counter with a delayed-branch nPC and a circular return-address stack.
// Updates in priority order: trap, stall, return, branch, sequential.
module pc_unit #(
  parameter int unsigned          WIDTH     = 32,
  parameter int unsigned          STEP      = 4,
  parameter logic [WIDTH-1:0]     RESET_VEC = '0,
  parameter logic [WIDTH-1:0]     TRAP_VEC  = WIDTH'(32'h0000_0080),
  parameter int unsigned          RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             le,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] target,
  input  logic             call,
  input  logic             ret,
  input  logic             trap,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] npc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  localparam int unsigned      PW      = $clog2(RAS_DEPTH);
  localparam int unsigned      CW      = $clog2(RAS_DEPTH) + 1;
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] STEP2_W = WIDTH'(2 * STEP);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    top_q, top_d, top_inc, top_dec, wr_idx;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] pc_d, npc_d, wr_data;
  logic             err_d, wr_en, stk_empty, stk_full;

  assign stk_empty = (cnt_q == '0);
  assign stk_full  = (cnt_q == CW'(RAS_DEPTH));
  assign ras_empty = stk_empty;
  assign ras_full  = stk_full;

  // Top pointer neighbours, wrapping at the stack depth (depth need not be a power of two).
  assign top_inc = (top_q == PW'(RAS_DEPTH - 1)) ? '0 : top_q + PW'(1);
  assign top_dec = (top_q == '0) ? PW'(RAS_DEPTH - 1) : top_q - PW'(1);

  // Next-state for PC/nPC, stack pointer/count and the sticky error flag.
  always_comb begin
    pc_d    = pc;
    npc_d   = npc;
    top_d   = top_q;
    cnt_d   = cnt_q;
    err_d   = ras_err;
    wr_en   = 1'b0;
    wr_idx  = top_inc;
    wr_data = pc + STEP2_W;
    if (trap) begin
      pc_d  = TRAP_VEC;
      npc_d = TRAP_VEC + STEP_W;
    end else if (le) begin
      pc_d  = npc;
      npc_d = npc + STEP_W;
      if (ret) begin
        if (!stk_empty) npc_d = ras_mem[top_q];
        else            err_d = 1'b1;
      end else if (branch_taken) begin
        npc_d = target;
      end
      if (call && ret && !stk_empty) begin
        // Pop and push cancel out: the new return address replaces the top.
        wr_en  = 1'b1;
        wr_idx = top_q;
      end else if (call) begin
        // A push into a full stack lands on the oldest slot.
        wr_en = 1'b1;
        top_d = top_inc;
        if (stk_full) err_d = 1'b1;
        else          cnt_d = cnt_q + CW'(1);
      end else if (ret && !stk_empty) begin
        top_d = top_dec;
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // Architectural state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_VEC;
      npc     <= RESET_VEC + STEP_W;
      top_q   <= '0;
      cnt_q   <= '0;
      ras_err <= 1'b0;
    end else begin
      pc      <= pc_d;
      npc     <= npc_d;
      top_q   <= top_d;
      cnt_q   <= cnt_d;
      ras_err <= err_d;
    end
  end

  // Stack storage is not reset; entries are only readable while the count is non-zero.
  always_ff @(posedge clk) begin
    if (wr_en) ras_mem[wr_idx] <= wr_data;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 32: PC/nPC width in bits.
REQ-002 Parameter STEP, default 4: sequential increment in bytes.
REQ-003 Parameter RESET_VEC, default 0: PC value at reset; nPC resets to RESET_VEC+STEP.
REQ-004 Parameter TRAP_VEC, default 32'h0000_0080: PC value loaded on trap.
REQ-005 Parameter RAS_DEPTH, default 4, legal range 2..16: return-address stack entries.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-008 le  input  1  load enable; 0 = stall (hold PC, nPC and stack).
REQ-009 branch_taken  input  1  redirect nPC to target (delayed branch).
REQ-010 target  input  WIDTH  branch/call destination.
REQ-011 call  input  1  push return address (PC+2*STEP) onto the stack.
REQ-012 ret  input  1  redirect nPC to top of stack and pop.
REQ-013 trap  input  1  redirect to TRAP_VEC; ignores le.
REQ-014 pc  output  WIDTH  current fetch address (registered).
REQ-015 npc  output  WIDTH  next fetch address (registered).
REQ-016 ras_empty  output  1  stack holds 0 entries (combinational from count).
REQ-017 ras_full  output  1  stack holds RAS_DEPTH entries.
REQ-018 ras_err  output  1  sticky: set on pop from empty or push to full.

Function
REQ-019 Update priority, highest first: trap, then le=0 (hold), then ret, then branch_taken, then sequential.
REQ-020 trap=1: pc<=TRAP_VEC, npc<=TRAP_VEC+STEP next edge; stack unchanged; call/ret/branch_taken ignored that cycle.
REQ-021 le=0 and trap=0: pc, npc, stack contents, count and ras_err all hold.
REQ-022 Sequential (le=1, no redirect): pc<=npc, npc<=npc+STEP; one-cycle latency, no bubbles.
REQ-023 branch_taken=1, ret=0: pc<=npc, npc<=target; the instruction at old npc is the delay slot.
REQ-024 ret=1, stack non-empty: pc<=npc, npc<=top entry, count decrements.
REQ-025 ret=1, stack empty: behaves as sequential, ras_err<=1, count stays 0.
REQ-026 call=1 with le=1 and trap=0: push pc+2*STEP; call combines with branch_taken or ret (the control flow is set by REQ-023/024).
REQ-027 call=1 with stack full: circular overwrite of the oldest entry, count stays RAS_DEPTH, ras_err<=1.
REQ-028 call=1 and ret=1 same cycle, stack non-empty: npc<=old top, new address replaces top, count unchanged.
REQ-029 call=1 and ret=1, stack empty: push occurs (count becomes 1), npc sequential, ras_err<=1.
REQ-030 All address arithmetic modulo 2^WIDTH; carries out of bit WIDTH-1 are discarded (wrap to 0).
REQ-031 Stack implemented as circular buffer with top pointer and count of width clog2(RAS_DEPTH)+1; pointer wraps at RAS_DEPTH.
REQ-032 ras_err clears only on reset.
REQ-033 No output depends combinationally on call, ret, branch_taken, target or trap.

Reset
REQ-034 reset=0 forces immediately, without waiting for clk: pc=RESET_VEC, npc=RESET_VEC+STEP, count=0, top pointer=0, ras_err=0.
REQ-035 Stack entry contents are not reset; they are unobservable while count=0.
REQ-036 Reset asserted mid-operation overrides every input, including trap; the first update after release follows REQ-019.

Verification
REQ-037 Reset then 3 cycles le=1 -> pc 0,4,8,12; npc 4,8,12,16; ras_empty=1.
REQ-038 At pc=8, branch_taken=1, target=0x100 -> next pc=0xC (delay slot), then pc=0x100, npc=0x104.
REQ-039 call with branch_taken at pc=0x20, target=0x200; later ret -> npc=0x28, count returns to 0.
REQ-040 RAS_DEPTH+1 calls at pc 0x10,0x20,... -> ras_full=1, ras_err=1; RAS_DEPTH rets return newest-first, with the oldest entry lost.
REQ-041 le=0 with branch_taken, call and ret all held at 1 -> pc, npc and count frozen; trap=1 during the stall -> pc=0x80, npc=0x84.
REQ-042 WIDTH=8, STEP=4, pc=0xF8 sequential -> npc wraps 0xFC then 0x00; reset pulse mid-run -> pc=0 asynchronously, ras_err=0.
